rob_commit_ctrl: RTL and testbench

In-order commit sequencer for the register file. It allocates ROB tags to the decoder and captures CDB writebacks into a circular entry buffer. It retires the head entry into the register file at most once per cycle, and drives the single-cycle rollback pulse on a mispredicted branch at head. It is the only block that drives the register file's commit and rollback inputs.

---
 rtl/rob_commit_ctrl.sv | 156 +++++++++++++++
 tb/tb_rob_commit_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit_ctrl.sv
// rtl/rob_commit_ctrl.sv - in-order ROB commit sequencer; optional same-cycle CDB-to-head commit via ROB_CDB_BYPASS_EN
module rob_commit_ctrl #(
  parameter int TAG_WIDTH  = 4,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dec_alloc_in,
  input  logic [4:0]            dec_rd_in,
  input  logic                  dec_has_rd_in,
  input  logic                  dec_is_branch_in,
  output logic [TAG_WIDTH-1:0]  dec_next_tag_out,
  output logic                  rob_full_out,
  input  logic                  cdb_valid_in,
  input  logic [TAG_WIDTH-1:0]  cdb_tag_in,
  input  logic [WORD_WIDTH-1:0] cdb_data_in,
  input  logic                  cdb_mispredict_in,
  input  logic [WORD_WIDTH-1:0] cdb_target_pc_in,
  output logic                  rf_commit_signal_out,
  output logic [TAG_WIDTH-1:0]  rf_commit_tag_out,
  output logic [WORD_WIDTH-1:0] rf_commit_data_out,
  output logic [4:0]            rf_commit_target_out,
  output logic                  rollback_out,
  output logic [WORD_WIDTH-1:0] rollback_pc_out
);
  localparam int NUM_SLOTS = 1 << TAG_WIDTH;
  localparam logic [TAG_WIDTH-1:0] TAG_ONE = TAG_WIDTH'(1);
  // Usable tags are 1..TAG_MAX, so the ROB depth equals the all-ones tag value.
  localparam logic [TAG_WIDTH-1:0] TAG_MAX = '1;

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;
  state_t state, state_next;

  // Slot 0 exists only so tags index the arrays directly; it is never allocated.
  logic [NUM_SLOTS-1:0]  ent_valid, ent_ready, ent_has_rd, ent_is_branch, ent_mispredict;
  logic [4:0]            ent_rd        [NUM_SLOTS];
  logic [WORD_WIDTH-1:0] ent_data      [NUM_SLOTS];
  logic [WORD_WIDTH-1:0] ent_target_pc [NUM_SLOTS];

  logic [TAG_WIDTH-1:0] head, tail, count;

  logic                  do_alloc, do_wb, bypass_hit, commit_fire, commit_mis, commit_writes_rd;
  logic [WORD_WIDTH-1:0] commit_data, commit_pc;

  function automatic logic [TAG_WIDTH-1:0] tag_inc(input logic [TAG_WIDTH-1:0] t);
    return (t == TAG_MAX) ? TAG_ONE : t + TAG_ONE;
  endfunction

  assign dec_next_tag_out = tail;
  assign rob_full_out     = (count == TAG_MAX);

  // State register for the RUN/FLUSH sequencer.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_next;
  end

  // Next state plus the per-cycle alloc / writeback / commit decisions.
  always_comb begin
    state_next       = state;
    do_alloc         = 1'b0;
    do_wb            = 1'b0;
    bypass_hit       = 1'b0;
    commit_fire      = 1'b0;
    commit_mis       = 1'b0;
    commit_data      = ent_data[head];
    commit_pc        = ent_target_pc[head];
    commit_writes_rd = ent_has_rd[head] && (ent_rd[head] != 5'd0);
    if (state == ST_RUN) begin
      do_alloc = dec_alloc_in && !rob_full_out;
      do_wb    = cdb_valid_in && (cdb_tag_in != '0) &&
                 ent_valid[cdb_tag_in] && !ent_ready[cdb_tag_in];
`ifdef ROB_CDB_BYPASS_EN
      bypass_hit = do_wb && (cdb_tag_in == head);
`endif
      commit_fire = ent_valid[head] && (ent_ready[head] || bypass_hit);
      if (bypass_hit) begin
        commit_data = cdb_data_in;
        commit_pc   = cdb_target_pc_in;
        commit_mis  = cdb_mispredict_in && ent_is_branch[head];
      end else begin
        commit_mis  = ent_mispredict[head];
      end
      if (commit_fire && commit_mis) state_next = ST_FLUSH;
    end else begin
      state_next = ST_RUN;
    end
  end

  // Entry payload; only meaningful while the matching valid bit is set, so no reset.
  // A mispredict flag is only kept for branches: nothing else can redirect fetch.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      ent_has_rd[tail]    <= dec_has_rd_in;
      ent_rd[tail]        <= dec_rd_in;
      ent_is_branch[tail] <= dec_is_branch_in;
    end
    if (do_wb) begin
      ent_data[cdb_tag_in]       <= cdb_data_in;
      ent_target_pc[cdb_tag_in]  <= cdb_target_pc_in;
      ent_mispredict[cdb_tag_in] <= cdb_mispredict_in && ent_is_branch[cdb_tag_in];
    end
  end

  // Pointers, occupancy, entry status bits and registered commit/rollback outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      head                 <= TAG_ONE;
      tail                 <= TAG_ONE;
      count                <= '0;
      ent_valid            <= '0;
      ent_ready            <= '0;
      rf_commit_signal_out <= 1'b0;
      rf_commit_tag_out    <= '0;
      rf_commit_data_out   <= '0;
      rf_commit_target_out <= 5'd0;
      rollback_out         <= 1'b0;
      rollback_pc_out      <= '0;
    end else begin
      rf_commit_signal_out <= 1'b0;
      rollback_out         <= 1'b0;
      if (do_wb) ent_ready[cdb_tag_in] <= 1'b1;
      if (do_alloc) begin
        ent_valid[tail] <= 1'b1;
        ent_ready[tail] <= 1'b0;
        tail            <= tag_inc(tail);
      end
      case ({do_alloc, commit_fire})
        2'b10:   count <= count + TAG_ONE;
        2'b01:   count <= count - TAG_ONE;
        default: count <= count;
      endcase
      if (commit_fire) begin
        if (commit_writes_rd) begin
          rf_commit_signal_out <= 1'b1;
          rf_commit_tag_out    <= head;
          rf_commit_data_out   <= commit_data;
          rf_commit_target_out <= ent_rd[head];
        end
        if (commit_mis) begin
          // Flush overrides any same-cycle allocation or writeback above.
          rollback_out    <= 1'b1;
          rollback_pc_out <= commit_pc;
          ent_valid       <= '0;
          ent_ready       <= '0;
          head            <= TAG_ONE;
          tail            <= TAG_ONE;
          count           <= '0;
        end else begin
          ent_valid[head] <= 1'b0;
          head            <= tag_inc(head);
        end
      end
    end
  end
endmodule

// File: tb/tb_rob_commit_ctrl.sv
// tb/tb_rob_commit_ctrl.sv - self-checking bench for rob_commit_ctrl
module tb_rob_commit_ctrl;
`ifdef ROB_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dec_alloc_in = 1'b0;
  logic [4:0]  dec_rd_in = 5'd0;
  logic        dec_has_rd_in = 1'b0;
  logic        dec_is_branch_in = 1'b0;
  logic [3:0]  dec_next_tag_out;
  logic        rob_full_out;
  logic        cdb_valid_in = 1'b0;
  logic [3:0]  cdb_tag_in = 4'd0;
  logic [31:0] cdb_data_in = 32'd0;
  logic        cdb_mispredict_in = 1'b0;
  logic [31:0] cdb_target_pc_in = 32'd0;
  logic        rf_commit_signal_out;
  logic [3:0]  rf_commit_tag_out;
  logic [31:0] rf_commit_data_out;
  logic [4:0]  rf_commit_target_out;
  logic        rollback_out;
  logic [31:0] rollback_pc_out;

  rob_commit_ctrl #(.TAG_WIDTH(4), .WORD_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .dec_alloc_in(dec_alloc_in), .dec_rd_in(dec_rd_in), .dec_has_rd_in(dec_has_rd_in),
    .dec_is_branch_in(dec_is_branch_in), .dec_next_tag_out(dec_next_tag_out),
    .rob_full_out(rob_full_out),
    .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_data_in(cdb_data_in),
    .cdb_mispredict_in(cdb_mispredict_in), .cdb_target_pc_in(cdb_target_pc_in),
    .rf_commit_signal_out(rf_commit_signal_out), .rf_commit_tag_out(rf_commit_tag_out),
    .rf_commit_data_out(rf_commit_data_out), .rf_commit_target_out(rf_commit_target_out),
    .rollback_out(rollback_out), .rollback_pc_out(rollback_pc_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the ROB as an in-order queue of in-flight instructions.
  typedef struct packed {
    logic [3:0]  tag;
    logic        hr;
    logic [4:0]  rd;
    logic        br;
    logic        rdy;
    logic [31:0] data;
    logic        mis;
    logic [31:0] pc;
  } ment_t;

  ment_t       q[$];
  logic [3:0]  m_next = 4'd1;
  bit          m_flush = 1'b0;
  logic        m_commit = 1'b0, m_rb = 1'b0;
  logic [3:0]  m_tag = 4'd0;
  logic [31:0] m_data = 32'd0, m_pc = 32'd0;
  logic [4:0]  m_tgt = 5'd0;

  task automatic model_edge();
    bit          full, cm, cmis;
    logic [31:0] cdata, cpc;
    ment_t       e;
    if (rst) begin
      q.delete(); m_next = 4'd1; m_flush = 1'b0;
      m_commit = 1'b0; m_rb = 1'b0; m_tag = 4'd0; m_data = 32'd0; m_tgt = 5'd0; m_pc = 32'd0;
      return;
    end
    m_commit = 1'b0;
    m_rb     = 1'b0;
    if (m_flush) begin
      m_flush = 1'b0;
      return;
    end
    full = (q.size() == 15);
    cm = 1'b0; cmis = 1'b0; cdata = 32'd0; cpc = 32'd0;
    if (q.size() > 0) begin
      if (q[0].rdy) begin
        cm = 1'b1; cdata = q[0].data; cmis = q[0].mis; cpc = q[0].pc;
      end else if (BYP && cdb_valid_in && cdb_tag_in == q[0].tag) begin
        cm = 1'b1; cdata = cdb_data_in; cmis = cdb_mispredict_in && q[0].br; cpc = cdb_target_pc_in;
      end
    end
    if (cdb_valid_in) begin
      foreach (q[k]) begin
        if (q[k].tag == cdb_tag_in && !q[k].rdy) begin
          q[k].rdy = 1'b1; q[k].data = cdb_data_in;
          q[k].mis = cdb_mispredict_in && q[k].br; q[k].pc = cdb_target_pc_in;
        end
      end
    end
    if (dec_alloc_in && !full) begin
      e = '{tag: m_next, hr: dec_has_rd_in, rd: dec_rd_in, br: dec_is_branch_in,
            rdy: 1'b0, data: 32'd0, mis: 1'b0, pc: 32'd0};
      q.push_back(e);
      m_next = (m_next == 4'd15) ? 4'd1 : m_next + 4'd1;
    end
    if (cm) begin
      e = q.pop_front();
      if (e.hr && e.rd != 5'd0) begin
        m_commit = 1'b1; m_tag = e.tag; m_data = cdata; m_tgt = e.rd;
      end
      if (cmis) begin
        m_rb = 1'b1; m_pc = cpc; q.delete(); m_next = 4'd1; m_flush = 1'b1;
      end
    end
  endtask

  logic [3:0] seen_tags[$];
  int         seen_cyc[$];
  int         rb_cnt = 0;
  logic [31:0] rb_pc_seen = 32'd0;

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    if (rf_commit_signal_out) begin
      seen_tags.push_back(rf_commit_tag_out);
      seen_cyc.push_back(cyc);
    end
    if (rollback_out) begin
      rb_cnt++;
      rb_pc_seen = rollback_pc_out;
    end
    chk("model_commit_strobe", rf_commit_signal_out, m_commit);
    chk("model_commit_tag", rf_commit_tag_out, m_tag);
    chk("model_commit_data", rf_commit_data_out, m_data);
    chk("model_commit_target", rf_commit_target_out, m_tgt);
    chk("model_rollback", rollback_out, m_rb);
    chk("model_rollback_pc", rollback_pc_out, m_pc);
    chk("model_next_tag", dec_next_tag_out, m_next);
    chk("model_full", rob_full_out, q.size() == 15);
  endtask

  task automatic step(input bit a, input bit [4:0] rd, input bit hr, input bit br,
                      input bit cv, input bit [3:0] ct, input bit [31:0] cd,
                      input bit cmis, input bit [31:0] cp);
    dec_alloc_in = a; dec_rd_in = rd; dec_has_rd_in = hr; dec_is_branch_in = br;
    cdb_valid_in = cv; cdb_tag_in = ct; cdb_data_in = cd;
    cdb_mispredict_in = cmis; cdb_target_pc_in = cp;
    tick();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;
    seen_tags.delete(); seen_cyc.delete(); rb_cnt = 0;
  endtask

  typedef struct packed {
    logic        alloc;
    logic [4:0]  rd;
    logic        hr;
    logic        cv;
    logic [3:0]  ct;
    logic [31:0] cd;
    logic        e_commit;
    logic [3:0]  e_tag;
    logic [31:0] e_data;
    logic [4:0]  e_tgt;
    logic [3:0]  e_next;
  } vec_t;

  vec_t vt[12];

  initial begin
    // Directed vectors: basic commit, no-strobe retires, held commit outputs.
    vt[0]  = '{1, 5'd5, 1, 0, 4'd0, 32'h0,      0,    4'd0,               32'h0,                           5'd0,               4'd2};
    vt[1]  = '{0, 5'd0, 0, 1, 4'd1, 32'hDEAD,   BYP,  BYP ? 4'd1 : 4'd0,  BYP ? 32'hDEAD : 32'h0,          BYP ? 5'd5 : 5'd0,  4'd2};
    vt[2]  = '{0, 5'd0, 0, 0, 4'd0, 32'h0,      !BYP, 4'd1,               32'hDEAD,                        5'd5,               4'd2};
    vt[3]  = '{0, 5'd0, 0, 0, 4'd0, 32'h0,      0,    4'd1,               32'hDEAD,                        5'd5,               4'd2};
    vt[4]  = '{1, 5'd9, 0, 0, 4'd0, 32'h0,      0,    4'd1,               32'hDEAD,                        5'd5,               4'd3};
    vt[5]  = '{1, 5'd0, 1, 0, 4'd0, 32'h0,      0,    4'd1,               32'hDEAD,                        5'd5,               4'd4};
    vt[6]  = '{0, 5'd0, 0, 1, 4'd3, 32'h7,      0,    4'd1,               32'hDEAD,                        5'd5,               4'd4};
    vt[7]  = '{0, 5'd0, 0, 1, 4'd2, 32'h9,      0,    4'd1,               32'hDEAD,                        5'd5,               4'd4};
    vt[8]  = '{0, 5'd0, 0, 0, 4'd0, 32'h0,      0,    4'd1,               32'hDEAD,                        5'd5,               4'd4};
    vt[9]  = '{1, 5'd7, 1, 0, 4'd0, 32'h0,      0,    4'd1,               32'hDEAD,                        5'd5,               4'd5};
    vt[10] = '{0, 5'd0, 0, 1, 4'd4, 32'h44,     BYP,  BYP ? 4'd4 : 4'd1,  BYP ? 32'h44 : 32'hDEAD,         BYP ? 5'd7 : 5'd5,  4'd5};
    vt[11] = '{0, 5'd0, 0, 0, 4'd0, 32'h0,      !BYP, 4'd4,               32'h44,                          5'd7,               4'd5};

    do_reset();
    chk("reset_strobe", rf_commit_signal_out, 0);
    chk("reset_tag", rf_commit_tag_out, 0);
    chk("reset_data", rf_commit_data_out, 0);
    chk("reset_target", rf_commit_target_out, 0);
    chk("reset_rollback", rollback_out, 0);
    chk("reset_rollback_pc", rollback_pc_out, 0);
    chk("reset_next_tag", dec_next_tag_out, 1);
    chk("reset_full", rob_full_out, 0);

    for (int i = 0; i < 12; i++) begin
      step(vt[i].alloc, vt[i].rd, vt[i].hr, 0, vt[i].cv, vt[i].ct, vt[i].cd, 0, 0);
      chk($sformatf("vec%0d_strobe", i), rf_commit_signal_out, vt[i].e_commit);
      chk($sformatf("vec%0d_tag", i), rf_commit_tag_out, vt[i].e_tag);
      chk($sformatf("vec%0d_data", i), rf_commit_data_out, vt[i].e_data);
      chk($sformatf("vec%0d_target", i), rf_commit_target_out, vt[i].e_tgt);
      chk($sformatf("vec%0d_next_tag", i), dec_next_tag_out, vt[i].e_next);
      chk($sformatf("vec%0d_rollback", i), rollback_out, 0);
      chk($sformatf("vec%0d_full", i), rob_full_out, 0);
    end

    // Fill to 15, over-allocate, free one slot, reuse wrapped tag 1.
    do_reset();
    for (int i = 0; i < 15; i++) step(1, 5'(i + 1), 1, 0, 0, 0, 0, 0, 0);
    chk("fill_full", rob_full_out, 1);
    chk("fill_next_wrapped", dec_next_tag_out, 1);
    step(1, 5'd20, 1, 0, 0, 0, 0, 0, 0);
    chk("over_alloc_full", rob_full_out, 1);
    chk("over_alloc_next", dec_next_tag_out, 1);
    step(0, 0, 0, 0, 1, 4'd1, 32'h100, 0, 0);
    idle();
    chk("free_one_full", rob_full_out, 0);
    chk("free_one_commit_tag", rf_commit_tag_out, 1);
    chk("free_one_commit_data", rf_commit_data_out, 32'h100);
    step(1, 5'd21, 1, 0, 0, 0, 0, 0, 0);
    chk("realloc_next", dec_next_tag_out, 2);
    chk("realloc_full", rob_full_out, 1);

    // Out-of-order writebacks 3,2,1 must commit 1,2,3 on consecutive cycles.
    do_reset();
    step(1, 5'd10, 1, 0, 0, 0, 0, 0, 0);
    step(1, 5'd11, 1, 0, 0, 0, 0, 0, 0);
    step(1, 5'd12, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 4'd3, 32'h33, 0, 0);
    step(0, 0, 0, 0, 1, 4'd2, 32'h22, 0, 0);
    step(0, 0, 0, 0, 1, 4'd1, 32'h11, 0, 0);
    for (int i = 0; i < 4; i++) idle();
    chk("ooo_count", seen_tags.size(), 3);
    if (seen_tags.size() == 3) begin
      chk("ooo_first", seen_tags[0], 1);
      chk("ooo_second", seen_tags[1], 2);
      chk("ooo_third", seen_tags[2], 3);
      chk("ooo_gap12", seen_cyc[1] - seen_cyc[0], 1);
      chk("ooo_gap23", seen_cyc[2] - seen_cyc[1], 1);
    end

    // Mispredicted branch at tag 2 with a ready tag 3 behind it.
    do_reset();
    step(1, 5'd1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 5'd0, 0, 1, 0, 0, 0, 0, 0);
    step(1, 5'd3, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 4'd3, 32'h33, 0, 0);
    step(0, 0, 0, 0, 1, 4'd2, 32'h0, 1, 32'h1000);
    step(0, 0, 0, 0, 1, 4'd1, 32'h11, 0, 0);
    for (int i = 0; i < 6; i++) if (rb_cnt == 0) idle();
    chk("mis_rollback_seen", rb_cnt, 1);
    chk("mis_rollback_pc", rb_pc_seen, 32'h1000);
    chk("mis_flush_next", dec_next_tag_out, 1);
    step(1, 5'd9, 1, 0, 0, 0, 0, 0, 0);
    chk("flush_alloc_dropped", dec_next_tag_out, 1);
    chk("flush_rollback_single", rollback_out, 0);
    for (int i = 0; i < 3; i++) idle();
    chk("mis_rollback_once", rb_cnt, 1);
    chk("mis_commits", seen_tags.size(), 1);
    if (seen_tags.size() >= 1) chk("mis_commit_tag", seen_tags[0], 1);
    step(1, 5'd9, 1, 0, 0, 0, 0, 0, 0);
    chk("post_flush_alloc", dec_next_tag_out, 2);

    // Randomized traffic against the queue model, with occasional resets.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      bit [3:0] t;
      rst = ($urandom_range(0, 199) == 0);
      if (q.size() > 0 && $urandom_range(0, 3) != 0) t = q[$urandom_range(0, q.size() - 1)].tag;
      else t = 4'($urandom_range(0, 15));
      step($urandom_range(0, 1), 5'($urandom_range(0, 3)), $urandom_range(0, 1),
           $urandom_range(0, 2) == 0, $urandom_range(0, 1), t, $urandom,
           $urandom_range(0, 5) == 0, $urandom);
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
